i2c_master_sequencer: RTL and testbench

Command-level sequencer placed between the APB register/command FIFO logic and the I2C `master` core. It accepts one transaction descriptor at a time and drives the master's configuration and `transaction_begin` inputs. It supervises the transfer through the master's status strobes, retries after lost arbitration with a fixed back-off, enforces a watchdog timeout, and returns a single completion status per command.

---
 rtl/i2c_master_sequencer_if.sv | 52 +++++
 rtl/i2c_master_sequencer.sv | 163 ++++++++++++++++
 tb/tb_i2c_master_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_sequencer_if.sv
// i2c_master_sequencer_if: command, master-control and status signals of the I2C sequencer.
// Rev 1.0 - initial release.
`default_nettype none

interface i2c_master_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_addr;
  logic       cmd_addr_mode;
  logic       cmd_dir;
  logic [5:0] cmd_size;

  logic [9:0] bus_address;
  logic       address_mode;
  logic       data_direction;
  logic [5:0] packet_size;
  logic       transaction_begin;
  logic       transaction_begin_clear;
  logic       set_transaction_complete;
  logic       set_arbitration_lost;
  logic       ack_error_set;
  logic       line_busy;

  logic       status_valid;
  logic       status_ready;
  logic [1:0] status_code;
  logic [1:0] status_retries;
  logic       timeout_abort;
  logic       seq_busy;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_addr, cmd_addr_mode, cmd_dir, cmd_size,
    input  transaction_begin_clear, set_transaction_complete, set_arbitration_lost,
    input  ack_error_set, line_busy, status_ready,
    output cmd_ready, bus_address, address_mode, data_direction, packet_size,
    output transaction_begin, status_valid, status_code, status_retries,
    output timeout_abort, seq_busy
  );

  // Command source / master core / status consumer side
  modport slave (
    output cmd_valid, cmd_addr, cmd_addr_mode, cmd_dir, cmd_size,
    output transaction_begin_clear, set_transaction_complete, set_arbitration_lost,
    output ack_error_set, line_busy, status_ready,
    input  cmd_ready, bus_address, address_mode, data_direction, packet_size,
    input  transaction_begin, status_valid, status_code, status_retries,
    input  timeout_abort, seq_busy
  );
endinterface

`default_nettype wire

// File: rtl/i2c_master_sequencer.sv
// i2c_master_sequencer: one-command-at-a-time driver for the I2C master core with retry and watchdog.
// Rev 1.0 - initial release.
`default_nettype none

module i2c_master_sequencer #(
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 256,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                    clk,
  input  logic                    n_rst,
  i2c_master_sequencer_if.master  bus
);
  localparam int          BW           = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam int          MR           = (MAX_RETRY > 3) ? 3 : MAX_RETRY;
  localparam logic [2:0]  MAX_RETRY_W  = 3'(MR);
  localparam logic [BW-1:0] BACKOFF_LOAD = BW'(BACKOFF_CYCLES - 1);
  localparam logic [20:0] WDOG_LAST    = 21'(TIMEOUT_CYCLES - 1);
  localparam logic [20:0] WDOG_MAX     = '1;
  localparam logic [1:0]  CODE_OK      = 2'd0;
  localparam logic [1:0]  CODE_NACK    = 2'd1;
  localparam logic [1:0]  CODE_ARB     = 2'd2;
  localparam logic [1:0]  CODE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LINE = 3'd1,
    S_BEGIN     = 3'd2,
    S_ACTIVE    = 3'd3,
    S_BACKOFF   = 3'd4,
    S_REPORT    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      bus_address_q, bus_address_d;
  logic            address_mode_q, address_mode_d;
  logic            data_direction_q, data_direction_d;
  logic [5:0]      packet_size_q, packet_size_d;
  logic [1:0]      retry_cnt_q, retry_cnt_d;
  logic            nack_q, nack_d;
  logic [BW-1:0]   backoff_q, backoff_d;
  logic [20:0]     wdog_q, wdog_d;
  logic [1:0]      status_code_q, status_code_d;
  logic            begin_q, begin_d;
  logic            abort_q, abort_d;

  always_comb begin
    state_d          = state_q;
    bus_address_d    = bus_address_q;
    address_mode_d   = address_mode_q;
    data_direction_d = data_direction_q;
    packet_size_d    = packet_size_q;
    retry_cnt_d      = retry_cnt_q;
    nack_d           = nack_q;
    backoff_d        = backoff_q;
    wdog_d           = wdog_q;
    status_code_d    = status_code_q;
    begin_d          = 1'b0;
    abort_d          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          bus_address_d    = bus.cmd_addr;
          address_mode_d   = bus.cmd_addr_mode;
          data_direction_d = bus.cmd_dir;
          packet_size_d    = bus.cmd_size;
          retry_cnt_d      = 2'd0;
          nack_d           = 1'b0;
          state_d          = S_WAIT_LINE;
        end
      end
      S_WAIT_LINE: begin
        if (!bus.line_busy) state_d = S_BEGIN;
      end
      S_BEGIN, S_ACTIVE: begin
        if (state_q == S_ACTIVE) begin
          wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 21'd1;
          if (bus.ack_error_set) nack_d = 1'b1;
        end
        // Arbitration loss outranks completion and timeout, in BEGIN as well as ACTIVE.
        if (bus.set_arbitration_lost) begin
          if ({1'b0, retry_cnt_q} < MAX_RETRY_W) begin
            retry_cnt_d = retry_cnt_q + 2'd1;
            backoff_d   = BACKOFF_LOAD;
            nack_d      = 1'b0;
            state_d     = S_BACKOFF;
          end else begin
            status_code_d = CODE_ARB;
            state_d       = S_REPORT;
          end
        end else if (state_q == S_BEGIN) begin
          if (bus.transaction_begin_clear) begin
            wdog_d  = '0;
            state_d = S_ACTIVE;
          end else begin
            begin_d = 1'b1;
          end
        end else if (bus.set_transaction_complete) begin
          status_code_d = (nack_q || bus.ack_error_set) ? CODE_NACK : CODE_OK;
          state_d       = S_REPORT;
        end else if (wdog_q == WDOG_LAST) begin
          abort_d       = 1'b1;
          status_code_d = CODE_TIMEOUT;
          state_d       = S_REPORT;
        end
      end
      S_BACKOFF: begin
        if (backoff_q == '0) state_d = S_WAIT_LINE;
        else                 backoff_d = backoff_q - BW'(1);
      end
      S_REPORT: begin
        if (bus.status_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q          <= S_IDLE;
      bus_address_q    <= '0;
      address_mode_q   <= 1'b0;
      data_direction_q <= 1'b0;
      packet_size_q    <= '0;
      retry_cnt_q      <= '0;
      nack_q           <= 1'b0;
      backoff_q        <= '0;
      wdog_q           <= '0;
      status_code_q    <= '0;
      begin_q          <= 1'b0;
      abort_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus_address_q    <= bus_address_d;
      address_mode_q   <= address_mode_d;
      data_direction_q <= data_direction_d;
      packet_size_q    <= packet_size_d;
      retry_cnt_q      <= retry_cnt_d;
      nack_q           <= nack_d;
      backoff_q        <= backoff_d;
      wdog_q           <= wdog_d;
      status_code_q    <= status_code_d;
      begin_q          <= begin_d;
      abort_q          <= abort_d;
    end
  end

  assign bus.cmd_ready         = (state_q == S_IDLE);
  assign bus.seq_busy          = (state_q != S_IDLE);
  assign bus.status_valid      = (state_q == S_REPORT);
  assign bus.status_code       = status_code_q;
  assign bus.status_retries    = retry_cnt_q;
  assign bus.bus_address       = bus_address_q;
  assign bus.address_mode      = address_mode_q;
  assign bus.data_direction    = data_direction_q;
  assign bus.packet_size       = packet_size_q;
  assign bus.transaction_begin = begin_q;
  assign bus.timeout_abort     = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_sequencer.sv
// tb_i2c_master_sequencer: directed self-checking bench for i2c_master_sequencer.
// Rev 1.0 - initial release.
`default_nettype none

module tb_i2c_master_sequencer;
  logic clk = 1'b0;
  logic n_rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  logic seen;

  i2c_master_sequencer_if bus();

  i2c_master_sequencer #(
    .MAX_RETRY      (3),
    .BACKOFF_CYCLES (256),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [9:0] a, input logic m, input logic d,
                         input logic [5:0] s);
    chk(tag, {14'd0, bus.bus_address, bus.address_mode, bus.data_direction, bus.packet_size},
        {14'd0, a, m, d, s});
  endtask

  task automatic accept(input logic [9:0] a, input logic m, input logic d, input logic [5:0] s);
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_addr_mode = m;
    bus.cmd_dir = d; bus.cmd_size = s;
    tick();
    bus.cmd_valid = 1'b0;
    // Scramble the descriptor inputs so later config checks prove the latch holds.
    bus.cmd_addr = ~a; bus.cmd_addr_mode = ~m; bus.cmd_dir = ~d; bus.cmd_size = ~s;
    chk_cfg("cfg_after_accept", a, m, d, s);
    chk("busy_ready_begin_after_accept",
        {29'd0, bus.seq_busy, bus.cmd_ready, bus.transaction_begin}, 32'b100);
  endtask

  task automatic start_xfer();
    tick();
    chk("begin_low_one_after_accept", bus.transaction_begin, 0);
    tick();
    chk("begin_high_two_after_accept", bus.transaction_begin, 1);
    bus.transaction_begin_clear = 1'b1;
    tick();
    bus.transaction_begin_clear = 1'b0;
    chk("begin_fall_after_clear", bus.transaction_begin, 0);
  endtask

  task automatic lose_and_retry(input logic with_complete);
    bus.set_arbitration_lost = 1'b1;
    bus.set_transaction_complete = with_complete;
    tick();
    bus.set_arbitration_lost = 1'b0;
    bus.set_transaction_complete = 1'b0;
    chk("no_status_after_arb_retry", bus.status_valid, 0);
    n = 0;
    while (bus.transaction_begin !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("backoff_plus_restart_cycles", n, 258);
    bus.transaction_begin_clear = 1'b1;
    tick();
    bus.transaction_begin_clear = 1'b0;
    chk("begin_fall_after_retry_clear", bus.transaction_begin, 0);
  endtask

  task automatic report(input string tag, input logic [1:0] code, input logic [1:0] retries);
    chk(tag, {27'd0, bus.status_valid, bus.status_code, bus.status_retries},
        {27'd0, 1'b1, code, retries});
  endtask

  task automatic handshake();
    bus.status_ready = 1'b1;
    tick();
    bus.status_ready = 1'b0;
    chk("idle_after_handshake", {30'd0, bus.cmd_ready, bus.status_valid}, 32'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: observed timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    n_rst = 1'b0;
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_addr_mode = 0; bus.cmd_dir = 0; bus.cmd_size = '0;
    bus.transaction_begin_clear = 0; bus.set_transaction_complete = 0;
    bus.set_arbitration_lost = 0; bus.ack_error_set = 0; bus.line_busy = 0; bus.status_ready = 0;
    tick(); tick();
    chk("reset_flags",
        {25'd0, bus.cmd_ready, bus.transaction_begin, bus.status_valid, bus.timeout_abort,
         bus.seq_busy, bus.status_code[1], bus.status_code[0]}, 32'b1000000);
    chk("reset_retries", bus.status_retries, 0);
    chk_cfg("reset_cfg", 10'd0, 1'b0, 1'b0, 6'd0);
    n_rst = 1'b1;
    tick();

    // Strobes in IDLE are ignored
    bus.set_transaction_complete = 1'b1; bus.set_arbitration_lost = 1'b1;
    tick();
    bus.set_transaction_complete = 1'b0; bus.set_arbitration_lost = 1'b0;
    chk("idle_ignores_strobes", {30'd0, bus.cmd_ready, bus.status_valid}, 32'b10);

    // TX 7-bit 0x066 size 4, ACKed
    accept(10'h066, 1'b0, 1'b0, 6'd4);
    start_xfer();
    tick(); tick();
    chk_cfg("cfg_stable_active", 10'h066, 1'b0, 1'b0, 6'd4);
    bus.set_transaction_complete = 1'b1;
    tick();
    bus.set_transaction_complete = 1'b0;
    report("ok_status", 2'd0, 2'd0);
    chk_cfg("cfg_stable_report", 10'h066, 1'b0, 1'b0, 6'd4);
    handshake();

    // NACK on byte 3 is sticky until completion
    accept(10'h00A, 1'b0, 1'b0, 6'd4);
    start_xfer();
    tick(); tick();
    bus.ack_error_set = 1'b1;
    tick();
    bus.ack_error_set = 1'b0;
    tick();
    bus.set_transaction_complete = 1'b1;
    tick();
    bus.set_transaction_complete = 1'b0;
    report("nack_status", 2'd1, 2'd0);
    handshake();

    // Two arbitration losses (second coincides with complete), then success
    accept(10'h123, 1'b1, 1'b0, 6'd2);
    start_xfer();
    lose_and_retry(1'b0);
    lose_and_retry(1'b1);
    bus.set_transaction_complete = 1'b1;
    tick();
    bus.set_transaction_complete = 1'b0;
    report("arb2_then_ok_status", 2'd0, 2'd2);
    handshake();

    // Four losses exhaust MAX_RETRY=3
    accept(10'h050, 1'b0, 1'b1, 6'd1);
    start_xfer();
    lose_and_retry(1'b0);
    lose_and_retry(1'b0);
    lose_and_retry(1'b0);
    bus.set_arbitration_lost = 1'b1;
    tick();
    bus.set_arbitration_lost = 1'b0;
    report("arb_exhausted_status", 2'd2, 2'd3);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.transaction_begin === 1'b1) seen = 1'b1;
    end
    chk("no_fifth_begin", seen, 0);
    report("arb_exhausted_held", 2'd2, 2'd3);
    handshake();

    // line_busy held for 1000 cycles after accept
    bus.line_busy = 1'b1;
    accept(10'h07F, 1'b0, 1'b0, 6'd3);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.transaction_begin !== 1'b0) seen = 1'b1;
    end
    chk("begin_low_while_busy", seen, 0);
    bus.line_busy = 1'b0;
    start_xfer();
    bus.set_transaction_complete = 1'b1;
    tick();
    bus.set_transaction_complete = 1'b0;
    report("line_busy_ok_status", 2'd0, 2'd0);
    handshake();

    // Watchdog timeout, 10-bit RX address-only transfer
    accept(10'h3FF, 1'b1, 1'b1, 6'd0);
    start_xfer();
    n = 0;
    while (bus.timeout_abort !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_abort_cycles", n, 64);
    report("timeout_status", 2'd3, 2'd0);
    tick();
    chk("timeout_abort_one_cycle", bus.timeout_abort, 0);
    report("timeout_status_held", 2'd3, 2'd0);
    chk_cfg("cfg_10bit_size0", 10'h3FF, 1'b1, 1'b1, 6'd0);
    handshake();

    // Asynchronous reset mid-ACTIVE
    accept(10'h155, 1'b0, 1'b1, 6'd7);
    start_xfer();
    repeat (10) tick();
    n_rst = 1'b0;
    #1;
    chk("async_reset_flags",
        {27'd0, bus.cmd_ready, bus.transaction_begin, bus.status_valid, bus.timeout_abort,
         bus.seq_busy}, 32'b10000);
    chk_cfg("async_reset_cfg", 10'd0, 1'b0, 1'b0, 6'd0);
    tick(); tick();
    n_rst = 1'b1;
    tick(); tick();
    chk("no_status_after_reset", {30'd0, bus.cmd_ready, bus.status_valid}, 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
